// File: rtl/clk_div_gen.sv
// clk_div_gen -- multi-channel programmable clock divider / tick generator.
//
// Each channel counts a phase p through an effective period D = max(div,1).
// It emits a registered level clk_out (high while p < high) and a one-cycle
// tick at phase 0. New div/high values are written into a shadow register
// and only become active on the channel's wrap edge (p == D-1). This keeps
// every period and high pulse whole.
//
// Optional feature macro: CLKGEN_SYNC_EN. When it is defined, a `sync` input
// exists. It realigns all channels to phase 0 and applies any pending config
// immediately.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   en           global count enable
//   cfg_we       config write strobe
//   cfg_ch       target channel (indices >= CHANNELS are ignored)
//   cfg_div      period in clk cycles (0 behaves as 1)
//   cfg_high     high cycles per period
//   sync         realign all channels (CLKGEN_SYNC_EN only)
//   clk_out      divided level per channel
//   tick         phase-0 pulse per channel
//   cfg_pending  shadow config waiting for its channel's wrap edge

// One divider channel.
module clk_div_gen_chan #(
  parameter int DIV_WIDTH  = 8,
  parameter int RESET_DIV  = 2,
  parameter int RESET_HIGH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 we,
  input  logic [DIV_WIDTH-1:0] wdiv,
  input  logic [DIV_WIDTH-1:0] whigh,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 pend
);
  logic [DIV_WIDTH-1:0] p, div, high, pdiv, phigh, plast;
  logic                 wrap;

  // Last phase of the period. div==0 behaves like div==1, so the last phase is 0.
  assign plast = (div == '0) ? '0 : div - DIV_WIDTH'(1);
  assign wrap  = (p == plast);

  always_ff @(posedge clk) begin
    if (reset) begin
      p       <= '0;
      div     <= DIV_WIDTH'(RESET_DIV);
      high    <= DIV_WIDTH'(RESET_HIGH);
      pdiv    <= '0;
      phigh   <= '0;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (sync) begin
        p       <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
        if (pend) begin
          div  <= pdiv;
          high <= phigh;
        end
      end else if (en) begin
        tick    <= (p == '0);
        clk_out <= (p < high);
        if (wrap) begin
          p <= '0;
          if (pend) begin
            div  <= pdiv;
            high <= phigh;
          end
        end else begin
          p <= p + DIV_WIDTH'(1);
        end
      end else begin
        tick <= 1'b0;
      end

      // A write on the same edge as a load still lands in the shadow.
      // The value loaded into active is the one that was pending before this edge.
      if (we) begin
        pdiv  <= wdiv;
        phigh <= whigh;
        pend  <= 1'b1;
      end else if (sync || (en && wrap)) begin
        pend <= 1'b0;
      end
    end
  end
endmodule

module clk_div_gen #(
  parameter int CHANNELS   = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int RESET_DIV  = 2,
  parameter int RESET_HIGH = 1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_high,
`ifdef CLKGEN_SYNC_EN
  input  logic                 sync,
`endif
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  cfg_pending
);
  logic sync_i;
`ifdef CLKGEN_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic we_i;
    // An out-of-range cfg_ch matches no channel, so that write is dropped.
    assign we_i = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_gen_chan #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_DIV (RESET_DIV),
      .RESET_HIGH(RESET_HIGH)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sync   (sync_i),
      .we     (we_i),
      .wdiv   (cfg_div),
      .whigh  (cfg_high),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .pend   (cfg_pending[i])
    );
  end
endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Synthesisable multi-channel programmable clock divider and tick generator for the RV64F processor. It runs entirely in the `clk` domain and produces, per channel, a divided 50%-or-programmable-duty level output and a single-cycle tick pulse at each period start. It replaces free-running behavioural clock models wherever slow timebases are needed, for example timers, the UART baud rate or debug strobes. Divisor and duty changes are shadowed and applied only at period boundaries, so outputs never glitch.

## Interface
- `CHANNELS`, 4: number of independent divider channels (≥1)
- `DIV_WIDTH`, 8: width of divisor/high-time fields
- `RESET_DIV`, 2: divisor loaded into every channel at reset
- `RESET_HIGH`, 1: high-time loaded into every channel at reset
- `CH_W` (localparam): max(1, $clog2(CHANNELS))

Ports:
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  global count enable
- `cfg_we`  in  1  write strobe for channel configuration
- `cfg_ch`  in  CH_W  channel index for write
- `cfg_div`  in  DIV_WIDTH  period in `clk` cycles (0 treated as 1)
- `cfg_high`  in  DIV_WIDTH  cycles per period that `clk_out` is high
- `sync`  in  1  realign all channels (only with `CLKGEN_SYNC_EN`)
- `clk_out`  out  CHANNELS  divided level output per channel, registered
- `tick`  out  CHANNELS  one-cycle pulse at phase 0 per channel, registered
- `cfg_pending`  out  CHANNELS  shadow config waiting for the period boundary

## Operation
- Per-channel state: phase `p` (DIV_WIDTH), active `div`/`high`, shadow `pdiv`/`phigh`, `pend` flag.
- Effective divisor D = max(div, 1).
- On an enabled edge (`en`=1):
  - `tick[i]` <= (p==0)
  - `clk_out[i]` <= (p < high)
  - then p <= (p == D-1) ? 0 : p+1
- Wrap edge is defined as p == D-1. On a wrap edge with `pend`=1:
  - div <= pdiv, high <= phigh
  - pend clears
  - the new values govern from phase 0 onward
- `high`=0: `clk_out` stays low. `high` ≥ D: `clk_out` stays high. `tick` is unaffected in both cases.
- D=1: every enabled edge is phase 0 and a wrap, so `tick` stays high continuously.
- `en`=0:
  - p, `clk_out` and active config hold
  - `tick` <= 0
  - shadow writes are still accepted
- `cfg_we`=1 with `cfg_ch` < CHANNELS: pdiv/phigh <= cfg values and pend <= 1. Later writes before the boundary overwrite earlier ones. `cfg_ch` ≥ CHANNELS: the write is ignored.
- Write and wrap on the same edge for the same channel:
  - any previously pending values load into active
  - the new write becomes pending, with pend remaining 1
- `cfg_pending` = pend flags, registered.

## Timing
- Reset (synchronous, dominates all inputs):
  - p=0, div=RESET_DIV, high=RESET_HIGH, pdiv=phigh=0
  - pend=0, `clk_out`=0, `tick`=0, `cfg_pending`=0
- Output latency: the phase value p appears on `tick`/`clk_out` one edge later.
- First enabled edge after reset: `tick`=1 on every channel, and `clk_out`=(RESET_HIGH>0).
- Config latency: a write is visible on `cfg_pending` after 1 edge. It takes effect at the next wrap edge, then appears on outputs starting the edge after that.
- Reset mid-period: discards phase and pending config immediately.

## Configuration
- `CLKGEN_SYNC_EN` defined:
  - the `sync` port exists
  - `sync`=1 on an edge, regardless of `en`: all p <= 0, every pending config loads into active immediately, pend clears, and `tick`/`clk_out` <= 0
  - the next enabled edge emits phase 0 (tick) on all channels simultaneously
  - `sync` priority: below `reset`, above counting and wrap loading
  - `cfg_we` on the same edge as `sync` becomes pending
- Undefined: no `sync` port, and channels align only via reset.

## Test plan
- Reset defaults: reset, then `en`=1 for 8 cycles with RESET_DIV=2, RESET_HIGH=1.
  - `tick` = 1,0,1,0…
  - `clk_out` = 1,0,1,0… on all channels
  - all outputs 0 during reset
- Divide and duty: write ch1 div=5, high=2, then run.
  - after the boundary, ch1 `clk_out` = 1,1,0,0,0 repeating
  - `tick` every 5th cycle
  - `cfg_pending[1]` high until the wrap edge
- Glitch-free update: mid-period on ch0 (div=4, p=1), write div=3.
  - current period completes as 4 cycles, then the period becomes 3
  - no shortened high pulse
- Edge values: div=0, then high=0, then high=9 with div=4.
  - div=0: `tick` constantly 1
  - high=0: `clk_out` constantly 0
  - high=9, div=4: `clk_out` constantly 1
- Enable and range: drop `en` for 3 cycles mid-period.
  - phase resumes unchanged and `tick` stays 0 while `en` is low
  - `cfg_ch`=CHANNELS write: no state change
- Sync (macro defined): channels at different phases, `sync` pulsed.
  - the next enabled edge has `tick`=all ones
  - a pending write is applied without waiting for a wrap
